// File: rtl/pinky_pkg.sv
// Shared PinKY definitions: opcodes, condition codes, instruction field ranges,
// the PRE prefix tag and the program-writer state encoding.
package pinky_pkg;

  localparam logic [4:0] OPADD = 5'b00000;
  localparam logic [4:0] OPAND = 5'b00010;
  localparam logic [4:0] OPOR  = 5'b00011;
  localparam logic [4:0] OPXOR = 5'b00100;
  localparam logic [4:0] OPMOV = 5'b01000;
  localparam logic [4:0] OPSUB = 5'b10001;
  localparam logic [4:0] OPSYS = 5'b10011;
  localparam logic [4:0] OPNOP = 5'b10100;
  localparam logic [4:0] OPPRE = 5'b11000;

  localparam logic [1:0] CC_AL = 2'd0;
  localparam logic [1:0] CC_S  = 2'd1;
  localparam logic [1:0] CC_NE = 2'd2;
  localparam logic [1:0] CC_EQ = 2'd3;

  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 11;
  localparam int CC_HI     = 10;
  localparam int CC_LO     = 9;
  localparam int IMM_BIT   = 8;
  localparam int DEST_HI   = 7;
  localparam int DEST_LO   = 4;
  localparam int OP2_HI    = 3;
  localparam int OP2_LO    = 0;
  localparam int PRE_HI    = 11;
  localparam int PRE_LO    = 0;

  localparam logic [3:0]  PRE_TAG  = 4'b1100;
  localparam logic [15:0] SYS_WORD = {OPSYS, 11'b0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_INST,
    ST_HALT,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/pinky_word_pack.sv
// Combinational packer: classifies a request as short/long and builds both the
// instruction word and the PRE prefix word that carries imm[15:4].
module pinky_word_pack
  import pinky_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [1:0]  cc,
  input  logic        imm_flag,
  input  logic [3:0]  dest,
  input  logic [3:0]  op2_reg,
  input  logic [15:0] imm,
  output logic        is_long,
  output logic [15:0] inst_word,
  output logic [15:0] pre_word
);

  logic imm_fits;

  always_comb begin
    // Fits the 4-bit sign-extended op2 when bits 15..3 are all copies of one value.
    imm_fits = (&imm[15:3]) | ~(|imm[15:3]);
    is_long  = imm_flag & ~imm_fits;

    inst_word                      = '0;
    inst_word[OPCODE_HI:OPCODE_LO] = op;
    inst_word[CC_HI:CC_LO]         = cc;
    inst_word[IMM_BIT]             = imm_flag;
    inst_word[DEST_HI:DEST_LO]     = dest;
    inst_word[OP2_HI:OP2_LO]       = imm_flag ? imm[3:0] : op2_reg;

    pre_word                 = '0;
    pre_word[15:12]          = PRE_TAG;
    pre_word[PRE_HI:PRE_LO]  = imm[15:4];
  end

endmodule

// File: rtl/pinky_inst_encoder.sv
// PinKY instruction-memory program writer. Optional build macro
// PINKY_ENC_AUTO_HALT_EN appends a SYS word after the in_last instruction.
module pinky_inst_encoder
  import pinky_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [1:0]  in_cc,
  input  logic        in_imm_flag,
  input  logic [3:0]  in_dest,
  input  logic [3:0]  in_op2_reg,
  input  logic [15:0] in_imm,
  input  logic        in_last,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [15:0] wr_count,
  output logic        done
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

`ifdef PINKY_ENC_AUTO_HALT_EN
  localparam enc_state_e EXIT_STATE = ST_HALT;
`else
  localparam enc_state_e EXIT_STATE = ST_DONE;
`endif

  enc_state_e  state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] held_word_q, held_word_d;
  logic        held_last_q, held_last_d;
  logic        done_q, done_d;

  logic        is_long;
  logic [15:0] inst_word;
  logic [15:0] pre_word;
  logic [1:0]  need;
  logic        accept;

  pinky_word_pack u_word_pack (
    .op        (in_op),
    .cc        (in_cc),
    .imm_flag  (in_imm_flag),
    .dest      (in_dest),
    .op2_reg   (in_op2_reg),
    .imm       (in_imm),
    .is_long   (is_long),
    .inst_word (inst_word),
    .pre_word  (pre_word)
  );

  // A request is taken only when every word it produces fits, so it is never split.
  always_comb begin
    need = is_long ? 2'd2 : 2'd1;
`ifdef PINKY_ENC_AUTO_HALT_EN
    if (in_last) need = need + 2'd1;
`endif
    in_ready = (state_q == ST_IDLE) && !done_q &&
               (({1'b0, wr_count_q} + 17'(need)) <= DEPTH_W);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch of the case can infer a latch.
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_count_d  = wr_count_q;
    held_word_d = held_word_q;
    held_last_d = held_last_q;
    done_d      = done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_count_q;
          wr_count_d  = wr_count_q + 16'd1;
          held_last_d = in_last;
          if (is_long) begin
            mem_wdata_d = pre_word;
            held_word_d = inst_word;
            state_d     = ST_EMIT_INST;
          end else begin
            mem_wdata_d = inst_word;
            if (in_last) state_d = EXIT_STATE;
          end
        end
      end
      ST_EMIT_INST: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_count_q;
        mem_wdata_d = held_word_q;
        wr_count_d  = wr_count_q + 16'd1;
        state_d     = held_last_q ? EXIT_STATE : ST_IDLE;
      end
`ifdef PINKY_ENC_AUTO_HALT_EN
      ST_HALT: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_count_q;
        mem_wdata_d = SYS_WORD;
        wr_count_d  = wr_count_q + 16'd1;
        state_d     = ST_DONE;
      end
`endif
      ST_DONE: done_d = 1'b1;
      default: state_d = ST_IDLE;
    endcase

    // clear wins over any accept in the same cycle.
    if (clear) begin
      state_d     = ST_IDLE;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      wr_count_d  = '0;
      held_last_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_count_q  <= '0;
      held_word_q <= '0;
      held_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_count_q  <= wr_count_d;
      held_word_q <= held_word_d;
      held_last_q <= held_last_d;
      done_q      <= done_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_count  = wr_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pinky_inst_encoder.sv
// Self-checking bench for pinky_inst_encoder (DEPTH=4): a write-stream model
// checked every cycle plus directed literal expectations.
module tb_pinky_inst_encoder;
  import pinky_pkg::*;

  localparam int DEPTH = 4;
`ifdef PINKY_ENC_AUTO_HALT_EN
  localparam int HALT_WORDS = 1;
`else
  localparam int HALT_WORDS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [1:0]  in_cc = '0;
  logic        in_imm_flag = 1'b0;
  logic [3:0]  in_dest = '0;
  logic [3:0]  in_op2_reg = '0;
  logic [15:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] wr_count;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pinky_inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_cc       (in_cc),
    .in_imm_flag (in_imm_flag),
    .in_dest     (in_dest),
    .in_op2_reg  (in_op2_reg),
    .in_imm      (in_imm),
    .in_last     (in_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .wr_count    (wr_count),
    .done        (done)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t wlog[$];

  int cyc          = 0;
  int m_reserved   = 0;
  int m_written    = 0;
  int m_busy_until = 0;
  int m_done_at    = -1;
  bit m_last       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model: plain arithmetic over the request fields ----
  function automatic logic [15:0] model_word(input int op, input int cc, input int flag,
                                             input int dest, input int op2);
    return 16'(op * 2048 + cc * 512 + flag * 256 + dest * 16 + op2);
  endfunction

  function automatic bit model_long();
    int s;
    s = int'($signed(in_imm));
    return in_imm_flag && (s < -8 || s > 7);
  endfunction

  function automatic int model_need();
    int n;
    n = model_long() ? 2 : 1;
    if (in_last) n += HALT_WORDS;
    return n;
  endfunction

  function automatic bit model_ready();
    return !m_last && (cyc >= m_busy_until) && ((DEPTH - m_reserved) >= model_need());
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_reserved   = 0;
    m_written    = 0;
    m_busy_until = 0;
    m_done_at    = -1;
    m_last       = 1'b0;
  endtask

  task automatic model_accept();
    int n, k, op2;
    bit lng;
    n   = cyc;
    lng = model_long();
    op2 = in_imm_flag ? (int'(in_imm) % 16) : int'(in_op2_reg);
    if (lng) begin
      exp_q.push_back('{n + 1, 16'(m_reserved), 16'hC000 | (in_imm >> 4)});
      exp_q.push_back('{n + 2, 16'(m_reserved + 1),
                        model_word(int'(in_op), int'(in_cc), 1, int'(in_dest), op2)});
      k = 2;
    end else begin
      exp_q.push_back('{n + 1, 16'(m_reserved),
                        model_word(int'(in_op), int'(in_cc), int'(in_imm_flag), int'(in_dest), op2)});
      k = 1;
    end
    if (in_last) begin
`ifdef PINKY_ENC_AUTO_HALT_EN
      exp_q.push_back('{n + k + 1, 16'(m_reserved + k), 16'h9800});
`endif
      k += HALT_WORDS;
      m_last    = 1'b1;
      m_done_at = n + k + 1;
    end
    m_busy_until = lng ? n + 2 : n + 1;
    m_reserved  += k;
  endtask

  // ---- compare process: every negedge ----
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (reset) begin
      model_reset();
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_wr_count", 32'(wr_count), 0);
      check("rst_done", 32'(done), 0);
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("wr_we", 32'(mem_we), 1);
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
        m_written++;
        wlog.push_back('{cyc, mem_addr, mem_wdata});
      end else begin
        check("mem_we_idle", 32'(mem_we), 0);
      end
      check("wr_count", 32'(wr_count), 32'(m_written));
      check("done", 32'(done), 32'(m_done_at >= 0 && cyc >= m_done_at));
      check("in_ready", 32'(in_ready), 32'(model_ready()));
      if (clear) model_reset();
      else if (in_valid && model_ready()) model_accept();
    end
  end

  // ---- stimulus helpers ----
  task automatic set_req(input logic [4:0] op, input logic [1:0] cc, input logic flag,
                         input logic [3:0] dest, input logic [3:0] rg, input logic [15:0] imm,
                         input logic last);
    in_op = op; in_cc = cc; in_imm_flag = flag; in_dest = dest;
    in_op2_reg = rg; in_imm = imm; in_last = last;
  endtask

  task automatic send(input int max_cycles, output bit accepted);
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < max_cycles && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic req(input string name, input logic [4:0] op, input logic [1:0] cc,
                     input logic flag, input logic [3:0] dest, input logic [3:0] rg,
                     input logic [15:0] imm, input logic last);
    bit acc;
    set_req(op, cc, flag, dest, rg, imm, last);
    send(20, acc);
    check({name, "_accept"}, 32'(acc), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int idx, input logic [15:0] addr,
                           input logic [15:0] data);
    check({name, "_present"}, 32'(wlog.size() > idx), 1);
    if (wlog.size() > idx) begin
      check({name, "_addr"}, 32'(wlog[idx].addr), 32'(addr));
      check({name, "_data"}, 32'(wlog[idx].data), 32'(data));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("clr_wr_count", 32'(wr_count), 0);
    check("clr_done", 32'(done), 0);
    check("clr_mem_we", 32'(mem_we), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, elapsed %0t, limit 100000", $time);
    $fatal(1);
  end

  initial begin
    int n0;
    bit acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_lit_mem_we", 32'(mem_we), 0);
    check("rst_lit_mem_addr", 32'(mem_addr), 0);
    check("rst_lit_wr_count", 32'(wr_count), 0);
    check("rst_lit_done", 32'(done), 0);
    check("rst_lit_in_ready", 32'(in_ready), 1);
    reset = 1'b0;
    idle(1);

    // ADD r1,#5 -> 0x0115 @0
    n0 = wlog.size();
    req("add", OPADD, CC_AL, 1'b1, 4'd1, 4'd0, 16'h0005, 1'b0);
    idle(2);
    check_log("add", n0, 16'd0, 16'h0115);
    check("add_wr_count", 32'(wr_count), 1);

    // MOV r2,#0x1234 -> PRE 0xC123 @1, 0x4124 @2, in_ready low one cycle
    n0 = wlog.size();
    req("mov", OPMOV, CC_AL, 1'b1, 4'd2, 4'd0, 16'h1234, 1'b0);
    check("mov_stall", 32'(in_ready), 0);
    set_req(OPNOP, CC_AL, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b0);
    idle(1);
    check("mov_resume", 32'(in_ready), 1);
    idle(1);
    check_log("mov_pre", n0, 16'd1, 16'hC123);
    check_log("mov_inst", n0 + 1, 16'd2, 16'h4124);
    check("mov_consec", 32'(wlog[n0 + 1].cyc - wlog[n0].cyc), 1);
    check("mov_wr_count", 32'(wr_count), 3);

    // One slot left: long request stalls, never split
    set_req(OPMOV, CC_AL, 1'b1, 4'd5, 4'd0, 16'h0100, 1'b0);
    send(5, acc);
    check("long_stall", 32'(acc), 0);
    check("long_stall_wr_count", 32'(wr_count), 3);

    // Short in_last with one slot left
    n0 = wlog.size();
    set_req(OPADD, CC_EQ, 1'b0, 4'd6, 4'd9, 16'h0000, 1'b1);
`ifdef PINKY_ENC_AUTO_HALT_EN
    send(5, acc);
    check("last_no_sys_room", 32'(acc), 0);
    check("last_no_sys_wr_count", 32'(wr_count), 3);
`else
    send(10, acc);
    check("last_accept", 32'(acc), 1);
    idle(3);
    check_log("last_word", n0, 16'd3, 16'h0669);
    check("last_done", 32'(done), 1);
    check("last_wr_count", 32'(wr_count), 4);
    set_req(OPNOP, CC_AL, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b0);
    send(4, acc);
    check("after_done_ignored", 32'(acc), 0);
`endif
    do_clear();

    // SUB r3,#-3 then AND r4,r7 (cc=S) back-to-back
    n0 = wlog.size();
    req("sub", OPSUB, CC_AL, 1'b1, 4'd3, 4'd0, 16'hFFFD, 1'b0);
    req("and", OPAND, CC_S, 1'b0, 4'd4, 4'd7, 16'h0000, 1'b0);
    idle(2);
    check_log("sub", n0, 16'd0, 16'h893D);
    check_log("and", n0 + 1, 16'd1, 16'h1247);
    check("sub_and_consec", 32'(wlog[n0 + 1].cyc - wlog[n0].cyc), 1);

    // Two slots free: short in_last fits (with SYS when halting is built in)
    n0 = wlog.size();
    req("last2", OPMOV, CC_NE, 1'b0, 4'd8, 4'd1, 16'h0000, 1'b1);
    idle(4);
    check_log("last2_word", n0, 16'd2, 16'h4481);
`ifdef PINKY_ENC_AUTO_HALT_EN
    check_log("last2_sys", n0 + 1, 16'd3, 16'h9800);
`endif
    check("last2_done", 32'(done), 1);
    check("last2_wr_count", 32'(wr_count), 32'(3 + HALT_WORDS));
    set_req(OPNOP, CC_AL, 1'b0, 4'd0, 4'd0, 16'h0000, 1'b0);
    send(4, acc);
    check("last2_ignored", 32'(acc), 0);
    check("last2_ignored_wr_count", 32'(wr_count), 32'(3 + HALT_WORDS));
    check("last2_done_sticky", 32'(done), 1);
    do_clear();

    // Reset during EMIT_INST: PRE stays written, instruction word dropped
    n0 = wlog.size();
    req("mov_rst", OPMOV, CC_AL, 1'b1, 4'd2, 4'd0, 16'h1234, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arst_mem_we", 32'(mem_we), 0);
    check("arst_mem_addr", 32'(mem_addr), 0);
    check("arst_mem_wdata", 32'(mem_wdata), 0);
    check("arst_wr_count", 32'(wr_count), 0);
    check("arst_done", 32'(done), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(3);
    check_log("mov_rst_pre", n0, 16'd0, 16'hC123);
    check("mov_rst_one_write", 32'(wlog.size() - n0), 1);
    check("mov_rst_wr_count", 32'(wr_count), 0);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pinky_inst_encoder.md
# pinky_inst_encoder

Program writer for the PinKY pipeline's instruction memory. Accepts one symbolic instruction per handshake (opcode, condition code, destination, and either a register or a full 16-bit immediate). Emits the encoded 16-bit words as sequential writes into instruction memory. Immediates that do not fit the 4-bit sign-extended op2 field are split into a PRE prefix word followed by the instruction word, so the pair rebuilds the value exactly as the fetch/decode stages expect.

## Interface
- DEPTH, 7: number of instruction-memory words writable (addresses 0..DEPTH-1).
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous; returns to IDLE with address 0 and done cleared.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted on a posedge where in_valid && in_ready.
- in_op  in  5  PinKY opcode.
- in_cc  in  2  condition code (AL=0, S=1, NE=2, EQ=3).
- in_imm_flag  in  1  1 selects immediate op2; 0 selects register op2.
- in_dest  in  4  destination register.
- in_op2_reg  in  4  op2 register; used when in_imm_flag=0.
- in_imm  in  16  immediate; used when in_imm_flag=1.
- in_last  in  1  marks the final instruction of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  16  write address.
- mem_wdata  out  16  write data.
- wr_count  out  16  next free address, equal to the number of words written.
- done  out  1  program complete; sticky until clear or reset.

## Operation
- Short form: in_imm_flag=0, or in_imm[15:3] all equal (value fits 4-bit sign extension).
  - Word = {in_op, in_cc, in_imm_flag, in_dest, op2}.
  - op2 = in_op2_reg when in_imm_flag=0, otherwise in_imm[3:0].
- Long form: in_imm_flag=1 and in_imm[15:3] not all equal.
  - First word PRE = {4'b1100, in_imm[15:4]}.
  - Second word = {in_op, in_cc, 1'b1, in_dest, in_imm[3:0]}.
- States and transitions:
  - IDLE: accepts requests. Short form stays in IDLE. Long form goes to EMIT_INST.
  - EMIT_INST: writes the held instruction word, then returns to IDLE, or leaves for the in_last exit.
  - DONE: no requests accepted.
- in_last exit:
  - With the macro, the exit is HALT then DONE.
  - Without the macro, the exit is DONE directly.
- in_ready = (state==IDLE) && !done && free >= need. free = DEPTH - wr_count; need = 1 for short form, 2 for long form. in_ready depends on the request fields by design.
- A long request with exactly one free slot is stalled, never split. The upstream must drop or reorder it.
- wr_count increments by 1 per mem_we. It never exceeds DEPTH, so there is no wrap-around.
- clear has priority over an accept in the same cycle.
- in_valid while in_ready=0 has no effect. Fields must stay stable until accepted.

## Timing
- Reset values: state=IDLE, in_ready follows the IDLE rule (1 if DEPTH>=1), mem_we=0, mem_addr=0, mem_wdata=0, wr_count=0, done=0.
- mem_we, mem_addr and mem_wdata are registered. mem_we is high for one cycle per word.
- Short form accepted at edge T: word written in cycle T+1 at address wr_count(T). Back-to-back short requests sustain one word per cycle.
- Long form accepted at T: PRE in cycle T+1 at address a, instruction in T+2 at a+1. in_ready=0 during EMIT_INST.
- done rises the cycle after the last word is driven (the instruction word, or SYS with the macro).
- Reset mid-EMIT_INST: the pending instruction word is discarded, and the already-written PRE stays in memory. The upstream restarts the program from address 0.

## Configuration
- PINKY_ENC_AUTO_HALT_EN defined: after the final word of an in_last request, HALT writes SYS = {5'b10011, 11'b0} = 0x9800 at the next address.
  - need for an in_last request grows by 1, so a request without space for the SYS word is stalled.
- Undefined: HALT state absent, no SYS appended; need excludes the SYS slot.

## Structure
- Shared package pinky_pkg holds:
  - opcode constants (OPADD..OPPRE, OPSYS=5'b10011, OPNOP=5'b10100);
  - CC constants;
  - field ranges (OPCODE [15:11], CC [10:9], IMM [8], DEST [7:4], OP2 [3:0], PRE payload [11:0]);
  - the PRE tag 4'b1100;
  - the encoder state enum.
- One combinational sub-module, pinky_word_pack, returns the long/short flag, the instruction word and the PRE word from the request fields.

## Test plan
- ADD r1,#5 (op 00000, cc 0, imm 0x0005) at address 0 -> one write, 0x0115 at address 0; wr_count=1.
- MOV r2,#0x1234 -> 0xC123 at address a, then 0x4124 at a+1; in_ready=0 for exactly one cycle.
- SUB r3,#-3 (imm 0xFFFD) then AND r4,r7 with cc=S on consecutive edges -> 0x893D then 0x1247 in consecutive cycles.
- DEPTH=4 with wr_count=3:
  - long request -> in_ready stays 0, no write;
  - short request with in_last -> accepted; with the macro it stalls instead, and without the macro done=1, wr_count=4.
- With the macro, 2 slots free: short in_last request -> instruction word, then 0x9800, then done=1; a following in_valid is ignored until clear.
- Assert reset during EMIT_INST of MOV r2,#0x1234 -> PRE written, no second write; all outputs return to their reset values asynchronously.
